fb_scan_reader: RTL and testbench
=================================

FB_SCAN_READER -- requirements
Module: fb_scan_reader

Interface
REQ-001 Parameter FB_W, default 320, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 240, framebuffer height in lines.
REQ-003 Parameter BG_COLOR, default 8'h00, colour shown for active-video pixels outside the framebuffer area.
REQ-004 clk  input  1  single clock for the whole block; all logic rising-edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 hcount  input  10  current pixel column from timing generator.
REQ-007 vcount  input  10  current line from timing generator.
REQ-008 video_on  input  1  high during visible pixels.
REQ-009 hsync  input  1  horizontal sync from timing generator.
REQ-010 vsync  input  1  vertical sync from timing generator, same signal fed to buffer controller.
REQ-011 buffer_select  input  1  active (display) buffer index from buffer controller.
REQ-012 mem_addr  output  17  framebuffer read address.
REQ-013 mem_bank  output  1  buffer index being read.
REQ-014 mem_rd  output  1  read strobe; RAM returns mem_rdata one cycle after sampling mem_addr/mem_rd.
REQ-015 mem_rdata  input  8  RGB332 pixel from framebuffer RAM.
REQ-016 pixel_rgb  output  8  pixel to DAC.
REQ-017 hsync_o, vsync_o, de_o  output  1 each  sync and video_on delayed to align with pixel_rgb.

Function
REQ-018 Block SHALL keep internal bank_q, updated to buffer_select only on a cycle where vsync was 1 on the previous cycle and is 0 now (vsync falling edge).
REQ-019 mem_bank SHALL equal bank_q; buffer_select changes outside the vsync falling edge SHALL NOT affect mem_bank until the next falling edge (no mid-frame tearing).
REQ-020 Stage 1 (registered on edge E1 after inputs presented): mem_addr, mem_rd, in-area flag, delayed video_on/hsync/vsync.
REQ-021 Address with scaling: x=hcount>>1, y=vcount>>1, mem_addr=y*FB_W+x; in-area when hcount<2*FB_W and vcount<2*FB_H.
REQ-022 mem_rd SHALL be 1 only when video_on=1 and in-area; otherwise mem_rd=0 and mem_addr SHALL hold its previous value.
REQ-023 Stage 2 (E2): RAM presents mem_rdata; block forwards control flags one more stage.
REQ-024 Stage 3 (E3): pixel_rgb = mem_rdata if delayed video_on and in-area; BG_COLOR if delayed video_on and not in-area; 8'h00 if delayed video_on=0.
REQ-025 Total latency from hcount/vcount/video_on/hsync/vsync to pixel_rgb/de_o/hsync_o/vsync_o SHALL be exactly 3 clk cycles.
REQ-026 Address arithmetic SHALL be unsigned, computed at full width and truncated to 17 bits; max legal address FB_W*FB_H-1.
REQ-027 vsync falling edge coincident with video_on=1 SHALL still update bank_q; the pixel presented that cycle SHALL already use the new bank.

Reset
REQ-028 While reset=1 at a clock edge: bank_q, mem_addr, mem_rd, pixel_rgb, hsync_o, vsync_o, de_o and all pipeline flags SHALL be 0, and the stored previous-vsync SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL flush the pipeline; first valid pixel_rgb SHALL appear 3 cycles after reset deassertion.
REQ-030 Reset SHALL take priority over a simultaneous vsync falling edge (bank_q stays 0).

Configuration
REQ-031 Macro FB_SCALE2_EN defined: 2x pixel doubling per REQ-021 (640x480 active region from 320x240 buffer).
REQ-032 FB_SCALE2_EN undefined: 1:1 mapping, mem_addr=vcount*FB_W+hcount, in-area when hcount<FB_W and vcount<FB_H; all else unchanged.

Verification
REQ-033 FB_SCALE2_EN set, hcount=5, vcount=3, video_on=1 -> next cycle mem_addr=1*320+2=322, mem_rd=1; mem_rdata=8'hE0 after one more cycle -> pixel_rgb=8'hE0, de_o=1 at cycle 3.
REQ-034 hcount=700, vcount=10, video_on=1 -> mem_rd=0; pixel_rgb=BG_COLOR (8'h00) at cycle 3; same with BG_COLOR=8'h1C -> 8'h1C.
REQ-035 buffer_select toggled 0->1 mid-frame -> mem_bank stays 0; vsync pulse 1 then 0 -> mem_bank=1 on the cycle after vsync falls.
REQ-036 Reset pulse during active video with valid reads in flight -> all outputs 0 next cycle; pixels resume exactly 3 cycles after reset drop.
REQ-037 FB_SCALE2_EN undefined, hcount=319, vcount=239 -> mem_addr=76799, mem_rd=1; hcount=320 -> mem_rd=0, pixel_rgb=BG_COLOR.
REQ-038 hsync/vsync toggling pattern -> hsync_o/vsync_o reproduce it delayed exactly 3 cycles.

Source files
------------

// File: rtl/fb_scan_reader.sv
// rtl/fb_scan_reader.sv - framebuffer scan-out reader, 3-cycle pipeline, bank latched on vsync fall
// Optional FB_SCALE2_EN: 2x pixel doubling of the framebuffer onto the active region.
module fb_scan_reader #(
  parameter int         FB_W     = 320,
  parameter int         FB_H     = 240,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        buffer_select,
  output logic [16:0] mem_addr,
  output logic        mem_bank,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel_rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o
);

  localparam logic [31:0] W32 = 32'(FB_W);
  localparam logic [31:0] H32 = 32'(FB_H);

  logic [31:0] h32, v32;
  logic [16:0] addr_next;
  logic        in_area;
  logic        rd_next;

  logic        bank_q;
  logic        vsync_prev;
  logic        area1, de1, hs1, vs1;
  logic        area2, de2, hs2, vs2;

  assign h32 = {22'd0, hcount};
  assign v32 = {22'd0, vcount};

  always_comb begin
    in_area   = 1'b0;
    addr_next = 17'd0;
`ifdef FB_SCALE2_EN
    in_area   = (h32 < 2 * W32) && (v32 < 2 * H32);
    addr_next = 17'((v32 >> 1) * W32 + (h32 >> 1));
`else
    in_area   = (h32 < W32) && (v32 < H32);
    addr_next = 17'(v32 * W32 + h32);
`endif
    rd_next   = video_on && in_area;
  end

  assign mem_bank = bank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q     <= 1'b0;
      vsync_prev <= 1'b0;
      mem_addr   <= 17'd0;
      mem_rd     <= 1'b0;
      area1      <= 1'b0;
      de1        <= 1'b0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      area2      <= 1'b0;
      de2        <= 1'b0;
      hs2        <= 1'b0;
      vs2        <= 1'b0;
      pixel_rgb  <= 8'h00;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
      de_o       <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      // Bank switches on the same edge that issues the read, so that read already uses it.
      if (vsync_prev && !vsync)
        bank_q <= buffer_select;

      mem_rd <= rd_next;
      if (rd_next)
        mem_addr <= addr_next;
      area1 <= in_area;
      de1   <= video_on;
      hs1   <= hsync;
      vs1   <= vsync;

      area2 <= area1;
      de2   <= de1;
      hs2   <= hs1;
      vs2   <= vs1;

      if (!de2)
        pixel_rgb <= 8'h00;
      else if (area2)
        pixel_rgb <= mem_rdata;
      else
        pixel_rgb <= BG_COLOR;
      de_o    <= de2;
      hsync_o <= hs2;
      vsync_o <= vs2;
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb/tb_fb_scan_reader.sv - self-checking bench for fb_scan_reader against a per-pixel reference model
module tb_fb_scan_reader;

  localparam int         FB_W = 320;
  localparam int         FB_H = 240;
  localparam logic [7:0] BG   = 8'h1C;
`ifdef FB_SCALE2_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic        video_on, hsync, vsync, buffer_select;
  logic [16:0] mem_addr;
  logic        mem_bank, mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pixel_rgb;
  logic        hsync_o, vsync_o, de_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] pix;
    logic       de;
    logic       hs;
    logic       vs;
  } exp_t;
  exp_t q[$];

  logic        bank_m, prev_vs_m;
  logic [16:0] addr_m;

  always #5 clk = ~clk;

  fb_scan_reader #(.FB_W(FB_W), .FB_H(FB_H), .BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .buffer_select(buffer_select), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .pixel_rgb(pixel_rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
  );

  // Framebuffer contents: a fixed pattern of address and bank.
  function automatic logic [7:0] ram_f(input logic [16:0] a, input logic b);
    return a[7:0] ^ {a[16:13], a[11:8]} ^ (b ? 8'hA5 : 8'h00);
  endfunction

  always @(posedge clk)
    if (mem_rd) mem_rdata <= ram_f(mem_addr, mem_bank);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input int h, input int v, input logic von,
                      input logic hs, input logic vs, input logic bs);
    exp_t e;
    int   x, y;
    logic area, rd;
    @(negedge clk);
    reset = rst; hcount = 10'(h); vcount = 10'(v);
    video_on = von; hsync = hs; vsync = vs; buffer_select = bs;
    e = '0;
    rd = 1'b0;
    if (rst) begin
      bank_m = 1'b0; prev_vs_m = 1'b0; addr_m = 17'd0;
      foreach (q[i]) q[i] = '0;
    end else begin
      if (prev_vs_m && !vs) bank_m = bs;
      prev_vs_m = vs;
      x = h / SCALE;
      y = v / SCALE;
      area = (h < SCALE * FB_W) && (v < SCALE * FB_H);
      rd = von && area;
      if (rd) addr_m = 17'(y * FB_W + x);
      e.pix = !von ? 8'h00 : (area ? ram_f(17'(y * FB_W + x), bank_m) : BG);
      e.de = von; e.hs = hs; e.vs = vs;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, rd});
    chk("mem_addr", {15'd0, mem_addr}, {15'd0, addr_m});
    chk("mem_bank", {31'd0, mem_bank}, {31'd0, bank_m});
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("pixel_rgb", {24'd0, pixel_rgb}, {24'd0, e.pix});
      chk("de_o", {31'd0, de_o}, {31'd0, e.de});
      chk("hsync_o", {31'd0, hsync_o}, {31'd0, e.hs});
      chk("vsync_o", {31'd0, vsync_o}, {31'd0, e.vs});
    end
  endtask

  initial begin
    q.push_back('0);
    q.push_back('0);
    bank_m = 1'b0; prev_vs_m = 1'b0; addr_m = 17'd0;

    // Reset, with a vsync fall during reset that must not move the bank.
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("bank_after_reset", {31'd0, mem_bank}, 32'd0);

    // Last framebuffer pixel, then first pixel right of the buffer.
    step(0, SCALE * FB_W - 1, SCALE * FB_H - 1, 1, 0, 0, 0);
    chk("last_addr", {15'd0, mem_addr}, 32'd76799);
    chk("last_rd", {31'd0, mem_rd}, 32'd1);
    step(0, SCALE * FB_W, 10, 1, 0, 0, 0);
    chk("right_rd", {31'd0, mem_rd}, 32'd0);
    chk("right_hold", {15'd0, mem_addr}, 32'd76799);
    step(0, 700, 10, 1, 0, 0, 0);
    step(0, 700, 10, 1, 0, 0, 0);
    chk("bg_pixel", {24'd0, pixel_rgb}, {24'd0, BG});

    // buffer_select mid-frame is ignored until vsync falls.
    step(0, 5, 3, 1, 0, 0, 1);
    step(0, 6, 3, 1, 0, 0, 1);
    chk("bank_midframe", {31'd0, mem_bank}, 32'd0);
    step(0, 7, 3, 0, 0, 1, 1);
    step(0, 8, 3, 1, 0, 0, 1);
    chk("bank_on_vsync_fall", {31'd0, mem_bank}, 32'd1);
    step(0, 9, 3, 1, 1, 0, 0);
    step(0, 10, 3, 1, 0, 0, 0);
    step(0, 11, 3, 0, 1, 1, 0);

    // Reset while reads are in flight, then resume.
    step(0, 20, 4, 1, 0, 0, 0);
    step(0, 21, 4, 1, 0, 0, 0);
    step(1, 22, 4, 1, 1, 1, 1);
    chk("rst_pixel", {24'd0, pixel_rgb}, 32'd0);
    chk("rst_de", {31'd0, de_o}, 32'd0);
    for (int i = 0; i < 6; i++) step(0, 30 + i, 5, 1, i[0], 0, 0);

    // Randomized raster-ish traffic with occasional resets and vsync pulses.
    for (int i = 0; i < 600; i++) begin
      int h, v;
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 799))
                                     : int'($urandom_range(0, SCALE * FB_W + 8));
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 524))
                                     : int'($urandom_range(0, SCALE * FB_H + 4));
      step(($urandom_range(0, 63) == 0), h, v, ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
